// File: rtl/lms_fir_engine.sv
// Serial-MAC FIR output stage of the LMS filter: keeps the reference delay line,
// computes y = sum(w*x) >>> 16 and e = d - y once per accepted sample.
module lms_fir_engine #(
  parameter int TAPS = 32,
  parameter int DW   = 14,
  parameter int WW   = 32,
  parameter int AW   = 48,
  localparam int IW  = $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] d_in,
  output logic [IW-1:0]        w_idx,
  input  logic signed [WW-1:0] w_data,
  input  logic [IW-1:0]        rd_idx,
  output logic signed [DW-1:0] rd_reff,
  output logic signed [DW-1:0] y,
  output logic signed [DW-1:0] e,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic [31:0]          n
);

  typedef enum logic [1:0] {IDLE, MAC, FINAL} state_t;

  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam int PW = WW + DW;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx;
  logic signed [AW-1:0]  acc;
  logic signed [DW-1:0]  taps [TAPS];
  logic signed [DW-1:0]  d_lat;

  logic signed [DW-1:0]  tap_sel;
  logic signed [PW-1:0]  w_ext, t_ext, prod;
  logic signed [AW-1:0]  prod_ext;
  logic                  ovf_hi, ovf_lo;
  logic signed [DW-1:0]  ys, es;
  logic signed [DW:0]    diff;

  assign w_idx   = idx;
  assign busy    = (state_q != IDLE);
  assign rd_reff = taps[rd_idx];
  assign tap_sel = taps[idx];

  // Both operands widened to the full product width so the truncated multiply is exact.
  assign w_ext    = {{DW{w_data[WW-1]}}, w_data};
  assign t_ext    = {{WW{tap_sel[DW-1]}}, tap_sel};
  assign prod     = w_ext * t_ext;
  assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};

  // acc >>> 16 fits DW bits only when bits [AW-1:16+DW-1] are all copies of the sign.
  assign ovf_hi = !acc[AW-1] && (|acc[AW-2:16+DW-1]);
  assign ovf_lo =  acc[AW-1] && !(&acc[AW-2:16+DW-1]);
  assign ys     = ovf_hi ? SMAX : (ovf_lo ? SMIN : acc[16+DW-1:16]);
  assign diff   = {d_lat[DW-1], d_lat} - {ys[DW-1], ys};
  assign es     = (diff[DW] != diff[DW-1]) ? (diff[DW] ? SMIN : SMAX) : diff[DW-1:0];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (sample_valid) state_d = MAC;
      MAC:     if (idx == IW'(TAPS-1)) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      idx       <= '0;
      acc       <= '0;
      d_lat     <= '0;
      y         <= '0;
      e         <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      n         <= '0;
      for (int unsigned k = 0; k < TAPS; k++) taps[k] <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      unique case (state_q)
        IDLE: if (sample_valid) begin
          taps[0] <= x_in;
          for (int unsigned k = 1; k < TAPS; k++) taps[k] <= taps[k-1];
          d_lat <= d_in;
          acc   <= '0;
          idx   <= '0;
        end
        MAC: begin
          acc <= acc + prod_ext;
          idx <= idx + IW'(1);
        end
        FINAL: begin
          y         <= ys;
          e         <= es;
          out_valid <= 1'b1;
          n         <= n + 32'd1;
        end
        default: ;
      endcase
      if (sample_valid && state_q != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lms_fir_engine.sv
// Bench for lms_fir_engine: behavioural dot-product model with per-cycle compare,
// plus directed cases with hand-computed results.
module tb_lms_fir_engine;
  localparam int TAPS = 32;
  localparam int DW   = 14;
  localparam int WW   = 32;
  localparam int AW   = 48;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] x_in = '0;
  logic signed [DW-1:0] d_in = '0;
  logic [4:0]           w_idx;
  logic signed [WW-1:0] w_data;
  logic [4:0]           rd_idx = '0;
  logic signed [DW-1:0] rd_reff, y, e;
  logic                 out_valid, busy, overrun;
  logic [31:0]          n;
  logic signed [WW-1:0] wbank [TAPS];

  always #5 clk = ~clk;
  assign w_data = wbank[w_idx];

  lms_fir_engine #(.TAPS(TAPS), .DW(DW), .WW(WW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .sample_valid(sample_valid), .x_in(x_in), .d_in(d_in),
    .w_idx(w_idx), .w_data(w_data), .rd_idx(rd_idx), .rd_reff(rd_reff),
    .y(y), .e(e), .out_valid(out_valid), .busy(busy), .overrun(overrun), .n(n)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic longint clamp(input longint v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  // Reference model: a result is due TAPS+1 edges after acceptance.
  longint m_taps [TAPS];
  longint pend_y, pend_e, exp_y, exp_e, exp_n, sum;
  int     remaining = 0;
  bit     exp_ov = 0, exp_overrun = 0, armed = 0;

  always @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < TAPS; k++) m_taps[k] = 0;
      remaining = 0; exp_ov = 0; exp_overrun = 0;
      exp_y = 0; exp_e = 0; exp_n = 0; pend_y = 0; pend_e = 0;
      armed = 1;
    end else begin
      exp_ov = 0;
      if (remaining > 0) begin
        if (sample_valid) exp_overrun = 1;
        remaining--;
        if (remaining == 0) begin
          exp_y = pend_y; exp_e = pend_e; exp_ov = 1;
          exp_n = (exp_n + 1) & 64'hFFFF_FFFF;
        end
      end else if (sample_valid) begin
        for (int k = TAPS - 1; k > 0; k--) m_taps[k] = m_taps[k-1];
        m_taps[0] = x_in;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += longint'(wbank[k]) * m_taps[k];
        pend_y = clamp(sum >>> 16);
        pend_e = clamp(longint'(d_in) - pend_y);
        remaining = TAPS + 1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (armed) begin
      check("out_valid", out_valid, exp_ov);
      check("busy", busy, remaining > 0);
      check("overrun", overrun, exp_overrun);
      check("n", n, exp_n);
      check("y", y, exp_y);
      check("e", e, exp_e);
      check("w_idx", w_idx, (remaining >= 2) ? (TAPS + 1 - remaining) : 0);
      check("rd_reff", rd_reff, m_taps[rd_idx]);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input int x, input int d);
    sample_valid = 1'b1; x_in = DW'(x); d_in = DW'(d);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin tick(); cyc++; end
    check("done_timeout", out_valid, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0; sample_valid = 1'b1; x_in = DW'(55); d_in = DW'(66);
    tick(); tick();
    rstn = 1'b1; sample_valid = 1'b0;
  endtask

  task automatic set_all_weights(input int v);
    for (int k = 0; k < TAPS; k++) wbank[k] = v;
  endtask

  task automatic rand_weights();
    for (int k = 0; k < TAPS; k++) wbank[k] = int'($urandom_range(2097152)) - 1048576;
  endtask

  task automatic rd_check(input int idx, input int exp, input string name);
    rd_idx = 5'(idx);
    tick();
    check(name, rd_reff, exp);
  endtask

  int cyc;

  initial begin
    set_all_weights(0);

    // Reset held two edges with a strobe present
    rstn = 1'b0; sample_valid = 1'b1; x_in = DW'(55); d_in = DW'(66);
    tick(); tick();
    check("rst_y", y, 0); check("rst_e", e, 0); check("rst_n", n, 0);
    check("rst_out_valid", out_valid, 0); check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0); check("rst_w_idx", w_idx, 0);
    rstn = 1'b1; sample_valid = 1'b0;
    for (int r = 0; r < TAPS; r++) rd_check(r, 0, "rst_rd_reff");

    // Unity weight on tap 0
    wbank[0] = 32'h0001_0000;
    send(100, 300);
    wait_done(cyc);
    check("unity_latency", cyc, 33);
    check("unity_y", y, 100); check("unity_e", e, 200); check("unity_n", n, 1);

    // Delay-line ordering, unity weight on tap 1
    do_reset();
    set_all_weights(0);
    wbank[1] = 32'h0001_0000;
    send(1, 0); wait_done(cyc);
    send(2, 0); wait_done(cyc);
    send(3, 0); wait_done(cyc);
    check("dl_y", y, 2);
    rd_check(0, 3, "dl_rd0"); rd_check(1, 2, "dl_rd1");
    rd_check(2, 1, "dl_rd2"); rd_check(3, 0, "dl_rd3");

    // Saturation, both directions
    set_all_weights(32'h0010_0000);
    for (int i = 0; i < TAPS; i++) begin send(8191, -8192); wait_done(cyc); end
    check("sat_pos_y", y, 8191); check("sat_pos_e", e, -8192);
    for (int i = 0; i < TAPS; i++) begin send(-8192, 8191); wait_done(cyc); end
    check("sat_neg_y", y, -8192); check("sat_neg_e", e, 8191);

    // Overrun: second strobe arrives at E10
    do_reset();
    rand_weights();
    send(11, 22);
    repeat (9) tick();
    sample_valid = 1'b1; x_in = DW'(777); d_in = DW'(1);
    tick();
    sample_valid = 1'b0;
    check("ovr_set", overrun, 1);
    wait_done(cyc);
    check("ovr_latency", cyc, 23);
    send(33, 44);
    check("ovr_accept_busy", busy, 1);
    wait_done(cyc);
    check("ovr_sticky", overrun, 1);
    check("ovr_n", n, 2);
    rd_check(0, 33, "ovr_rd0"); rd_check(1, 11, "ovr_rd1");

    // Reset mid-MAC, then a clean computation
    do_reset();
    set_all_weights(0);
    wbank[0] = 32'h0001_0000;
    send(7, 7);
    repeat (14) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst_busy", busy, 0); check("midrst_n", n, 0);
    repeat (40) tick();
    check("midrst_n_hold", n, 0);
    send(5, 5);
    wait_done(cyc);
    check("midrst_y", y, 5); check("midrst_e", e, 0); check("midrst_n1", n, 1);

    // Randomized traffic; weights only change while idle
    for (int i = 0; i < 3000; i++) begin
      if (remaining == 0 && $urandom_range(3) == 0) rand_weights();
      rstn         = ($urandom_range(799) != 0);
      sample_valid = ($urandom_range(5) == 0);
      x_in         = DW'($urandom);
      d_in         = DW'($urandom);
      rd_idx       = 5'($urandom);
      tick();
    end
    rstn = 1'b1; sample_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
